// File: rtl/fifo_frame_packer.sv
//==============================================================================
// Module   : fifo_frame_packer
// Purpose  : Pops bytes from a 1-cycle-latency FIFO read port and emits framed
//            packets (SOF byte, 1..MAX_LEN payload bytes, XOR checksum with
//            out_last) on a valid/ready stream. Frames close at MAX_LEN bytes
//            or after TIMEOUT idle cycles.
// Options  : define FRAME_PACKER_STATS_EN to add the 16-bit frame_count output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_frame_packer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter int                    TIMEOUT    = 32,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef FRAME_PACKER_STATS_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int SUM_W  = CNT_W + 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SOF     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CHK     = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [DATA_WIDTH-1:0] r_buf [0:1];
  logic                  r_head;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_chk;
  logic [IDLE_W-1:0]     r_idle;

  logic                  w_hs;
  logic                  w_pop;
  logic                  w_tail;
  logic                  w_timeout;
  logic                  w_src_idle;
  logic                  w_room;
  logic                  w_budget;
  logic [2:0]            w_level;
  logic [SUM_W-1:0]      w_commit;

  assign w_hs       = out_valid && out_ready;
  assign w_pop      = (r_state == S_PAYLOAD) && w_hs;
  assign w_tail     = r_head ^ r_occ[0];
  // Bytes already owned by this frame but not yet sent: buffered plus in flight.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_room     = w_level < (3'd2 + {2'b00, w_pop});
  assign w_commit   = SUM_W'(r_cnt) + SUM_W'(w_level);
  assign w_budget   = w_commit < SUM_W'(MAX_LEN);
  assign w_src_idle = (r_occ == 2'd0) && !r_inflight && fifo_empty;
  assign w_timeout  = (r_state == S_PAYLOAD) && (r_idle == IDLE_W'(TIMEOUT)) &&
                      (r_cnt != '0);

  // The read is withheld on the timeout cycle: a byte fetched then would land
  // after the frame has already committed to its checksum.
  assign fifo_rd_en = rst_n && ((r_state == S_SOF) || (r_state == S_PAYLOAD)) &&
                      !fifo_empty && w_room && w_budget && !w_timeout;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!fifo_empty) w_next = S_SOF;
      S_SOF:     if (w_hs) w_next = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_pop && (r_cnt == CNT_W'(MAX_LEN - 1))) w_next = S_CHK;
        else if (w_timeout)                          w_next = S_CHK;
      end
      S_CHK:     if (w_hs) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode from state and registers only (no path from out_ready).
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (r_state)
      S_SOF: begin
        out_valid = 1'b1;
        out_data  = SOF_BYTE;
      end
      S_PAYLOAD: begin
        out_valid = (r_occ != 2'd0);
        out_data  = r_buf[r_head];
      end
      S_CHK: begin
        out_valid = 1'b1;
        out_data  = r_chk;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping: buffer pointers, payload count, checksum, idle timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_idle     <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
        r_cnt  <= r_cnt + 1'b1;
        r_chk  <= r_chk ^ r_buf[r_head];
      end else if ((r_state == S_CHK) && w_hs) begin
        r_cnt  <= '0;
        r_chk  <= '0;
      end
      if ((r_state == S_PAYLOAD) && (w_next == S_PAYLOAD) && w_src_idle) begin
        if (r_idle != IDLE_W'(TIMEOUT)) r_idle <= r_idle + 1'b1;
      end else begin
        r_idle <= '0;
      end
    end
  end

  // Returned read data lands at the buffer tail one cycle after the request.
  always_ff @(posedge clk) begin
    if (r_inflight) r_buf[w_tail] <= fifo_data_out;
  end

`ifdef FRAME_PACKER_STATS_EN
  logic [15:0] r_frame_count;

  // Completed-frame counter, bumped on each accepted checksum beat.
  always_ff @(posedge clk) begin
    if (!rst_n)                         r_frame_count <= 16'd0;
    else if ((r_state == S_CHK) && w_hs) r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_packer.sv
//==============================================================================
// Module   : tb_fifo_frame_packer
// Purpose  : Self-checking bench for fifo_frame_packer: cycle table for a full
//            frame, directed corner sequences and a randomized run checked by
//            a stream-level frame scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_frame_packer;

  localparam int         MAXL = 16;
  localparam int         TO   = 32;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_rd_en;
  logic [7:0] fifo_data_out;
  logic       fifo_empty;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
`ifdef FRAME_PACKER_STATS_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  fifo_frame_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last)
`ifdef FRAME_PACKER_STATS_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       rd;
  } vec_t;

  // FIFO contents, bytes read but not yet emitted, and the observed beats.
  logic [7:0] fq[$];
  logic [7:0] expq[$];
  logic [8:0] beats[$];
  int         beat_cyc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stream-level frame model.
  bit         in_frame, chk_pend, after_chk, stall_prev;
  int         plen, outstanding, run_m1, run_m2, frames;
  logic [7:0] xacc, prev_data;
  logic       prev_last;

  logic       s_valid, s_last, s_rd, s_rst;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    in_frame = 0; chk_pend = 0; after_chk = 0; stall_prev = 0;
    plen = 0; outstanding = 0; run_m1 = 0; run_m2 = 0; frames = 0;
    xacc = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample and score at negedge, then service the FIFO read port.
  task automatic step();
    logic       hs, cnd;
    logic [7:0] e;
    int         r_now;
    @(negedge clk);
    cyc++;
    s_valid = out_valid; s_data = out_data; s_last = out_last;
    s_rd = fifo_rd_en; s_rst = rst_n;
    if (rst_n) begin
      hs = out_valid && out_ready;
      check("buffered_plus_inflight_le_2", 32'(outstanding <= 2), 1);
      if (fifo_rd_en) check("no_read_when_empty", 32'(fifo_empty), 0);
      if (after_chk) check("idle_after_chk", 32'(out_valid), 0);
      if (stall_prev) begin
        check("stall_valid_hold", 32'(out_valid), 1);
        check("stall_data_hold", 32'(out_data), 32'(prev_data));
        check("stall_last_hold", 32'(out_last), 32'(prev_last));
      end
      if (chk_pend || (out_valid && out_last)) check("no_read_during_chk", 32'(fifo_rd_en), 0);
      if (out_valid && out_last && !chk_pend && in_frame && (plen < MAXL))
        check("timeout_latency", 32'(run_m2), TO);
`ifdef FRAME_PACKER_STATS_EN
      check("frame_count", 32'(frame_count), 32'(frames[15:0]));
`endif
      cnd = in_frame && !(out_valid && out_last) && fifo_empty && (outstanding == 0);
      if (hs) begin
        beats.push_back({out_last, out_data});
        beat_cyc.push_back(cyc);
        if (!in_frame) begin
          check("sof_byte", 32'(out_data), 32'(SOF));
          check("sof_not_last", 32'(out_last), 0);
          in_frame = 1; plen = 0; xacc = 8'h00;
        end else if (out_last) begin
          check("checksum", 32'(out_data), 32'(xacc));
          check("frame_nonempty", 32'(plen >= 1), 1);
          in_frame = 0; frames++;
        end else begin
          if (expq.size() == 0) begin
            check("payload_has_source", 0, 1);
          end else begin
            e = expq.pop_front();
            check("payload_byte", 32'(out_data), 32'(e));
          end
          plen++; xacc ^= out_data; outstanding--;
          check("payload_len_le_max", 32'(plen <= MAXL), 1);
        end
      end
      r_now  = cnd ? run_m1 + 1 : 0;
      run_m2 = run_m1;
      run_m1 = r_now;
      if (fifo_rd_en) outstanding++;
      if (out_valid && out_last && !hs) chk_pend = 1;
      if (hs && out_last) chk_pend = 0;
      after_chk  = hs && out_last;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    @(posedge clk);
    #1;
    if (s_rst && s_rd && (fq.size() > 0)) begin
      fifo_data_out = fq.pop_front();
      expq.push_back(fifo_data_out);
    end
    if (!s_rst) model_reset();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic wait_idle(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    beats.delete();
    beat_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [21];
    logic [8:0] exp_bp [18];
    logic [7:0] rem [$];
    logic [7:0] rx;
    int         t0;

    // Full-frame cycle table, cycle 0 = first IDLE cycle with data available.
    for (int i = 0; i < 21; i++) begin
      tbl[i].ready = 1'b1; tbl[i].valid = 1'b0; tbl[i].data = 8'h00;
      tbl[i].last  = 1'b0; tbl[i].rd = (i >= 1) && (i <= 16);
    end
    tbl[1].valid = 1'b1; tbl[1].data = SOF;
    for (int n = 1; n <= 16; n++) begin
      tbl[2 + n].valid = 1'b1; tbl[2 + n].data = 8'(n);
    end
    tbl[19].valid = 1'b1; tbl[19].data = 8'h10; tbl[19].last = 1'b1;

    exp_bp[0] = {1'b0, SOF};
    for (int n = 1; n <= 16; n++) exp_bp[n] = {1'b0, 8'(n)};
    exp_bp[17] = {1'b1, 8'h10};

    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data_out = 8'h00; out_ready = 1'b0;
    model_reset();
    step(); step(); step();
    rst_n = 1'b1;

    // Reset state.
    step();
    check("reset_out_valid", 32'(s_valid), 0);
    check("reset_out_last", 32'(s_last), 0);
    check("reset_out_data", 32'(s_data), 0);
    check("reset_rd_en", 32'(s_rd), 0);

    // Empty source.
    for (int i = 0; i < 100; i++) begin
      step();
      check("empty_src_rd_en", 32'(s_rd), 0);
      check("empty_src_valid", 32'(s_valid), 0);
    end

    // Full frame from the table.
    wait_idle(4);
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    for (int i = 0; i < 21; i++) begin
      out_ready = tbl[i].ready;
      step();
      check("full_valid", 32'(s_valid), 32'(tbl[i].valid));
      check("full_rd_en", 32'(s_rd), 32'(tbl[i].rd));
      if (tbl[i].valid) begin
        check("full_data", 32'(s_data), 32'(tbl[i].data));
        check("full_last", 32'(s_last), 32'(tbl[i].last));
      end
    end

    // Short frame closed by timeout.
    wait_idle(4);
    push(8'h01); push(8'h02); push(8'h04);
    t0 = cyc + 1;
    for (int i = 0; i < 100 && beats.size() < 5; i++) step();
    check("short_beat_count", beats.size(), 5);
    if (beats.size() == 5) begin
      check("short_b0", 32'(beats[0]), {23'd0, 1'b0, SOF});
      check("short_b1", 32'(beats[1]), 32'h001);
      check("short_b2", 32'(beats[2]), 32'h002);
      check("short_b3", 32'(beats[3]), 32'h004);
      check("short_chk", 32'(beats[4]), 32'h107);
      check("short_sof_latency", beat_cyc[0] - t0, 1);
      check("short_first_payload_gap", beat_cyc[1] - beat_cyc[0], 2);
      check("short_timeout_gap", beat_cyc[4] - beat_cyc[3], TO + 2);
    end

    // Backpressure: out_ready toggles every cycle.
    wait_idle(4);
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    for (int i = 0; i < 200 && beats.size() < 18; i++) begin
      out_ready = ~out_ready;
      step();
    end
    check("bp_beat_count", beats.size(), 18);
    for (int i = 0; i < 18 && i < beats.size(); i++)
      check("bp_beat", 32'(beats[i]), 32'(exp_bp[i]));

    // Reset mid-frame after SOF plus five payload beats.
    wait_idle(4);
    for (int i = 0; i < 16; i++) push(8'(8'h30 + 8'(i)));
    for (int i = 0; i < 40 && beats.size() < 6; i++) step();
    check("pre_reset_beats", beats.size(), 6);
    rst_n = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    rem = fq;
    beats.delete();
    step();
    check("midrst_valid", 32'(s_valid), 0);
    check("midrst_last", 32'(s_last), 0);
    check("midrst_rd_en", 32'(s_rd), 0);
    for (int i = 0; i < 200 && !(beats.size() > 0 && beats[beats.size() - 1][8]); i++) step();
    rx = 8'h00;
    foreach (rem[i]) rx ^= rem[i];
    check("midrst_next_len", beats.size(), rem.size() + 2);
    if (beats.size() > 1) begin
      check("midrst_next_sof", 32'(beats[0]), {23'd0, 1'b0, SOF});
      check("midrst_next_chk", 32'(beats[beats.size() - 1]), {23'd0, 1'b1, rx});
    end

    // Randomized traffic: bursts, trickle and silent gaps, random backpressure.
    wait_idle(4);
    for (int seg = 0; seg < 60; seg++) begin
      int mode, len;
      mode = $urandom_range(0, 2);
      len  = $urandom_range(5, 70);
      for (int k = 0; k < len; k++) begin
        if ((mode != 2) && ($urandom_range(0, 99) < ((mode == 0) ? 80 : 25)))
          push(8'($urandom));
        out_ready = ($urandom_range(0, 99) < 75);
        step();
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5000 && !((fq.size() == 0) && !in_frame && (outstanding == 0)); k++)
      step();
    for (int k = 0; k < 50; k++) step();
    check("drain_frame_closed", 32'(in_frame), 0);
    check("drain_fifo_empty", fq.size(), 0);
    check("drain_no_lost_bytes", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
